// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the dual-issue register scoreboard.
// Feature macro SCOREBOARD_DUAL_ISSUE_EN enables slot-1 issue and allocation.
package issue_scoreboard_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int REG_WIDTH = REG_IDX_W;

  localparam logic [2:0] POS_EXECUTE = 3'b100;
  localparam logic [2:0] POS_MEMORY  = 3'b010;
  localparam logic [2:0] POS_COMMIT  = 3'b001;
  localparam logic [2:0] POS_NONE    = 3'b000;

  typedef struct packed {
    logic [2:0] position;
    logic       line;
  } SCORE_BOARD_DATA;

  typedef struct packed {
    SCORE_BOARD_DATA data;
    logic            is_load;
  } sb_entry_t;

  // One pipeline step: execute -> memory -> commit -> gone.
  function automatic logic [2:0] age_position(input logic [2:0] pos);
    return {1'b0, pos[2:1]};
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Request/grant bundle between decode/issue and the scoreboard.
// Feature macro SCOREBOARD_DUAL_ISSUE_EN affects only how the scoreboard grants slot 1.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  // Handshake: req_valid[i] is a request for slot i; issue_grant[i] is the same-cycle
  // combinational answer, and an instruction is consumed only on a clock edge where
  // both are high. Requests must stay stable until granted or withdrawn.
  logic                            advance;
  logic                            flush;
  logic [1:0]                      req_valid;
  logic [1:0][REG_IDX_W-1:0]       req_dst;
  logic [1:0]                      req_wen;
  logic [1:0]                      req_is_load;
  logic [3:0][REG_IDX_W-1:0]       req_src;
  logic [3:0]                      req_src_used;
  logic [1:0]                      issue_grant;
  SCORE_BOARD_DATA [3:0]           score_board_data;
  logic [3:0]                      src_from_regfile;

  modport master (
    output advance, flush, req_valid, req_dst, req_wen, req_is_load, req_src, req_src_used,
    input  issue_grant, score_board_data, src_from_regfile
  );

  modport slave (
    input  advance, flush, req_valid, req_dst, req_wen, req_is_load, req_src, req_src_used,
    output issue_grant, score_board_data, src_from_regfile
  );

endinterface

// File: rtl/scoreboard_lookup.sv
// Single-operand scoreboard read: bypass descriptor, register-file select and readiness.
// Behaviour is the same with or without SCOREBOARD_DUAL_ISSUE_EN.
module scoreboard_lookup
  import issue_scoreboard_pkg::*;
(
    input  sb_entry_t                i_entry,
    input  logic [REG_IDX_W-1:0]     i_src,
    output SCORE_BOARD_DATA          o_data,
    output logic                     o_from_regfile,
    output logic                     o_ready
);

    logic w_from_regfile;

    assign w_from_regfile = (i_entry.data.position == POS_NONE) || (i_src == '0);
    assign o_from_regfile = w_from_regfile;
    assign o_data         = w_from_regfile ? '0 : i_entry.data;
    // A load still in execute has no value to bypass yet.
    assign o_ready        = w_from_regfile ||
                            !(i_entry.is_load && (i_entry.data.position == POS_EXECUTE));

endmodule

// File: rtl/issue_scoreboard.sv
// Per-register producer tracking, operand descriptors and dual-slot issue interlock.
// Define SCOREBOARD_DUAL_ISSUE_EN to let slot 1 issue and allocate; otherwise slot 0 only.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    issue_scoreboard_if.slave        sb
);

    sb_entry_t       r_entries [NUM_REGS];
    sb_entry_t       w_next    [NUM_REGS];
    sb_entry_t       w_entry   [4];
    SCORE_BOARD_DATA w_data    [4];
    logic [3:0]      w_from_rf;
    logic [3:0]      w_ready;
    logic            w_can_issue;
    logic            w_grant0;
    logic            w_grant1;

    for (genvar k = 0; k < 4; k++) begin : g_lookup
        assign w_entry[k] = r_entries[sb.req_src[k]];
        scoreboard_lookup u_lookup (
            .i_entry        (w_entry[k]),
            .i_src          (sb.req_src[k]),
            .o_data         (w_data[k]),
            .o_from_regfile (w_from_rf[k]),
            .o_ready        (w_ready[k])
        );
        assign sb.score_board_data[k] = w_data[k];
    end

    assign sb.src_from_regfile = w_from_rf;

    assign w_can_issue = !rst && sb.advance && !sb.flush;
    assign w_grant0    = w_can_issue && sb.req_valid[0] &&
                         (&(w_ready[1:0] | ~sb.req_src_used[1:0]));

`ifdef SCOREBOARD_DUAL_ISSUE_EN
    logic w_raw;

    // Slot 1 cannot bypass from its own pair partner in the same cycle.
    assign w_raw    = sb.req_wen[0] && (sb.req_dst[0] != '0) &&
                      ((sb.req_src_used[2] && (sb.req_src[2] == sb.req_dst[0])) ||
                       (sb.req_src_used[3] && (sb.req_src[3] == sb.req_dst[0])));
    assign w_grant1 = w_grant0 && sb.req_valid[1] && !w_raw &&
                      (&(w_ready[3:2] | ~sb.req_src_used[3:2]));
`else
    logic w_unused;

    assign w_grant1 = 1'b0;
    assign w_unused = ^{sb.req_valid[1], sb.req_dst[1], sb.req_wen[1], sb.req_is_load[1],
                        sb.req_src_used[3:2], w_ready[3:2]};
`endif

    assign sb.issue_grant = {w_grant1, w_grant0};

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_next[i] = r_entries[i];
            if (sb.advance) begin
                if (age_position(r_entries[i].data.position) == POS_NONE) begin
                    w_next[i] = '0;
                end else begin
                    w_next[i].data.position = age_position(r_entries[i].data.position);
                end
            end
        end
        if (w_grant0 && sb.req_wen[0] && (sb.req_dst[0] != '0)) begin
            w_next[sb.req_dst[0]].data.position = POS_EXECUTE;
            w_next[sb.req_dst[0]].data.line     = 1'b0;
            w_next[sb.req_dst[0]].is_load       = sb.req_is_load[0];
        end
`ifdef SCOREBOARD_DUAL_ISSUE_EN
        // Slot 1 is younger, so its write to a shared destination wins.
        if (w_grant1 && sb.req_wen[1] && (sb.req_dst[1] != '0)) begin
            w_next[sb.req_dst[1]].data.position = POS_EXECUTE;
            w_next[sb.req_dst[1]].data.line     = 1'b1;
            w_next[sb.req_dst[1]].is_load       = sb.req_is_load[1];
        end
`endif
        w_next[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_entries[i] <= '0;
        end else if (sb.flush) begin
            for (int i = 0; i < NUM_REGS; i++) r_entries[i] <= '0;
        end else begin
            r_entries <= w_next;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard; expectations adapt to SCOREBOARD_DUAL_ISSUE_EN.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

`ifdef SCOREBOARD_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  // Slot used for the load producer, and the grant expected when both slots are free to go.
  localparam int         LS     = DUAL ? 1 : 0;
  localparam logic [1:0] G_BOTH = DUAL ? 2'b11 : 2'b01;
  localparam logic [3:0] R9_EXE = {3'b100, DUAL};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  issue_scoreboard_if sb_if ();

  issue_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  // driver tasks
  task automatic idle();
    sb_if.advance      = 1'b1;
    sb_if.flush        = 1'b0;
    sb_if.req_valid    = '0;
    sb_if.req_dst      = '0;
    sb_if.req_wen      = '0;
    sb_if.req_is_load  = '0;
    sb_if.req_src      = '0;
    sb_if.req_src_used = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    // Reset with a full request pending on r5.
    sb_if.req_valid    = 2'b11;
    sb_if.req_src      = {4{5'd5}};
    sb_if.req_src_used = 4'b1111;
    tick();
    tick();
    chk("rst_grant", sb_if.issue_grant, 2'b00);
    chk("rst_regfile", sb_if.src_from_regfile, 4'b1111);
    chk("rst_data", sb_if.score_board_data, 16'h0000);
    rst = 1'b0;
    idle();

    // Slot 0 writes r3.
    sb_if.req_valid  = 2'b01;
    sb_if.req_wen    = 2'b01;
    sb_if.req_dst[0] = 5'd3;
    #1;
    chk("add_r3_grant", sb_if.issue_grant, 2'b01);
    tick();

    // Slot 0 reads r3, then watch it age out.
    idle();
    sb_if.req_valid    = 2'b01;
    sb_if.req_src[0]   = 5'd3;
    sb_if.req_src_used = 4'b0001;
    #1;
    chk("r3_exe_data", sb_if.score_board_data[0], 4'b1000);
    chk("r3_exe_rf", sb_if.src_from_regfile, 4'b1110);
    chk("r3_exe_grant", sb_if.issue_grant, 2'b01);
    tick();
    chk("r3_mem_data", sb_if.score_board_data[0], 4'b0100);
    tick();
    chk("r3_com_data", sb_if.score_board_data[0], 4'b0010);
    tick();
    chk("r3_gone_rf", sb_if.src_from_regfile, 4'b1111);
    chk("r3_gone_data", sb_if.score_board_data[0], 4'b0000);

    // Load r4, then load-use stall on slot 0.
    idle();
    sb_if.req_valid       = 2'b11;
    sb_if.req_wen[LS]     = 1'b1;
    sb_if.req_dst[LS]     = 5'd4;
    sb_if.req_is_load[LS] = 1'b1;
    #1;
    chk("ld_r4_grant", sb_if.issue_grant, G_BOTH);
    tick();
    idle();
    sb_if.req_valid    = 2'b01;
    sb_if.req_src[0]   = 5'd4;
    sb_if.req_src_used = 4'b0001;
    #1;
    chk("ld_use_grant", sb_if.issue_grant, 2'b00);
    chk("ld_use_data", sb_if.score_board_data[0], {3'b100, LS[0]});
    chk("ld_use_rf", sb_if.src_from_regfile, 4'b1110);
    tick();
    chk("ld_mem_data", sb_if.score_board_data[0], {3'b010, LS[0]});
    chk("ld_mem_grant", sb_if.issue_grant, 2'b01);
    tick();

    // Intra-pair RAW on r7: slot 1 must wait.
    idle();
    sb_if.req_valid    = 2'b11;
    sb_if.req_wen      = 2'b01;
    sb_if.req_dst[0]   = 5'd7;
    sb_if.req_src[2]   = 5'd7;
    sb_if.req_src_used = 4'b0100;
    #1;
    chk("raw_grant", sb_if.issue_grant, 2'b01);
    chk("raw_src2_rf", sb_if.src_from_regfile[2], 1'b1);
    tick();

    // Both slots write r9.
    idle();
    sb_if.req_valid = 2'b11;
    sb_if.req_wen   = 2'b11;
    sb_if.req_dst   = {5'd9, 5'd9};
    #1;
    chk("ww_r9_grant", sb_if.issue_grant, G_BOTH);
    tick();

    // Stall for 5 cycles with r7 in memory and r9 in execute.
    idle();
    sb_if.advance      = 1'b0;
    sb_if.req_valid    = 2'b01;
    sb_if.req_src[0]   = 5'd9;
    sb_if.req_src[1]   = 5'd7;
    sb_if.req_src_used = 4'b0011;
    #1;
    chk("r9_line", sb_if.score_board_data[0], R9_EXE);
    chk("r7_mem", sb_if.score_board_data[1], 4'b0100);
    chk("stall_grant", sb_if.issue_grant, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_r7_hold", sb_if.score_board_data[1], 4'b0100);
    chk("stall_r9_hold", sb_if.score_board_data[0], R9_EXE);

    // Flush overrides advance and clears everything.
    sb_if.advance = 1'b1;
    sb_if.flush   = 1'b1;
    #1;
    chk("flush_grant", sb_if.issue_grant, 2'b00);
    tick();
    sb_if.flush = 1'b0;
    #1;
    chk("flush_rf", sb_if.src_from_regfile, 4'b1111);
    chk("flush_data", sb_if.score_board_data, 16'h0000);
    chk("post_flush_grant", sb_if.issue_grant, 2'b01);

    // Async reset with r2 in flight.
    idle();
    sb_if.req_valid  = 2'b01;
    sb_if.req_wen    = 2'b01;
    sb_if.req_dst[0] = 5'd2;
    #1;
    tick();
    idle();
    sb_if.req_valid    = 2'b11;
    sb_if.req_src[0]   = 5'd2;
    sb_if.req_src_used = 4'b0001;
    #1;
    chk("r2_exe_data", sb_if.score_board_data[0], 4'b1000);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", sb_if.score_board_data, 16'h0000);
    chk("mid_rst_rf", sb_if.src_from_regfile, 4'b1111);
    chk("mid_rst_grant", sb_if.issue_grant, 2'b00);
    rst = 1'b0;
    #1;
    chk("post_rst_r2", sb_if.score_board_data[0], 4'b0000);
    chk("post_rst_grant", sb_if.issue_grant, G_BOTH);
    tick();

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
